// File: rtl/m2_block_scheduler.sv
// -----------------------------------------------------------------------------
// m2_block_scheduler
//
// Top-level sequencer for the milestone-2 IDCT datapath. It walks every 8x8
// block of the Y, U and V segments in raster order and drives the start/finish
// handshakes of the four sub-blocks: Fetch S' (FS), Compute T (CT),
// Compute S (CS) and Write S (WS).
//
// Schedule:
//   S_IDLE -> S_LI_FS -> S_LI_CT -> {S_CS_FS -> S_CT_WS}* -> S_LO_CS
//          -> S_LO_WS -> S_DONE -> S_IDLE
// FS and WS share the SRAM and are never overlapped. FS(k+1) runs alongside
// CS(k), and CT(k+1) runs alongside WS(k).
//
// Optional feature (macro M2_PERF_CNT_EN):
//   defined   -> perf_stall counts cycles in S_CS_FS/S_CT_WS where exactly one
//                of the two done flags is set; cleared on start accept and held
//                after finish.
//   undefined -> perf_stall is tied to 0 and no counter is built.
//
// Ports:
//   Clock_50                 in   system clock
//   Resetn                   in   asynchronous active-low reset
//   start                    in   begin a full-image pass (sampled in S_IDLE)
//   finish                   out  one-cycle pulse when the last WS completes
//   fs/ct/cs/ws_start        out  one-cycle launch pulses
//   fs/ct/cs/ws_finish       in   one-cycle done pulses from the sub-blocks
//   fs_seg/fs_row/fs_col     out  coordinates of the block being fetched
//   ws_seg/ws_row/ws_col     out  coordinates of the block being written
//   sram_sel                 out  SRAM owner: 0 = FS, 1 = WS
//   busy                     out  high from leaving S_IDLE until finish
//   perf_stall               out  stall-cycle count (see above)
// -----------------------------------------------------------------------------
module m2_block_scheduler #(
  parameter int BLK_ROWS    = 30,
  parameter int Y_BLK_COLS  = 40,
  parameter int UV_BLK_COLS = 20
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        start,
  output logic        finish,
  output logic        fs_start,
  output logic        ct_start,
  output logic        cs_start,
  output logic        ws_start,
  input  logic        fs_finish,
  input  logic        ct_finish,
  input  logic        cs_finish,
  input  logic        ws_finish,
  output logic [1:0]  fs_seg,
  output logic [4:0]  fs_row,
  output logic [5:0]  fs_col,
  output logic [1:0]  ws_seg,
  output logic [4:0]  ws_row,
  output logic [5:0]  ws_col,
  output logic        sram_sel,
  output logic        busy,
  output logic [31:0] perf_stall
);

  localparam logic [4:0] ROW_LAST    = 5'(BLK_ROWS - 1);
  localparam logic [5:0] Y_COL_LAST  = 6'(Y_BLK_COLS - 1);
  localparam logic [5:0] UV_COL_LAST = 6'(UV_BLK_COLS - 1);
  localparam logic [1:0] SEG_LAST    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LI_FS,
    S_LI_CT,
    S_CS_FS,
    S_CT_WS,
    S_LO_CS,
    S_LO_WS,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       leave;
  // High during the first cycle of every state; launches are registered off it
  // so each start pulse appears in the second cycle of its state.
  logic       entry;
  logic       armed;

  // Done flags of the two sub-blocks running in an overlapped state:
  // flag_a tracks CS (in S_CS_FS) or CT (in S_CT_WS), flag_b tracks FS or WS.
  logic       flag_a;
  logic       flag_b;
  logic       fin_a;
  logic       fin_b;
  logic       overlap;
  logic       both_done;

  // Next block to be fetched; copied into fs_* when FS is launched.
  logic [1:0] nxt_seg;
  logic [4:0] nxt_row;
  logic [5:0] nxt_col;
  logic [1:0] adv_seg;
  logic [4:0] adv_row;
  logic [5:0] adv_col;

  logic       fs_last;
  logic       fs_launch;
  logic       ws_load;

  // Raster-order successor of the next-fetch index.
  always_comb begin
    adv_seg = nxt_seg;
    adv_row = nxt_row;
    adv_col = nxt_col + 6'd1;
    if (nxt_col == ((nxt_seg == 2'd0) ? Y_COL_LAST : UV_COL_LAST)) begin
      adv_col = 6'd0;
      if (nxt_row == ROW_LAST) begin
        adv_row = 5'd0;
        adv_seg = nxt_seg + 2'd1;
      end else begin
        adv_row = nxt_row + 5'd1;
      end
    end
  end

  always_comb begin
    fs_last   = (fs_seg == SEG_LAST) && (fs_row == ROW_LAST) && (fs_col == UV_COL_LAST);
    armed     = !entry;
    overlap   = (state == S_CS_FS) || (state == S_CT_WS);
    fin_a     = 1'b0;
    fin_b     = 1'b0;
    if (state == S_CS_FS) begin
      fin_a = cs_finish;
      fin_b = fs_finish;
    end else if (state == S_CT_WS) begin
      fin_a = ct_finish;
      fin_b = ws_finish;
    end
    // A finish in the current cycle counts together with the stored flag, so
    // the state is left at the same edge that would have set the last flag.
    both_done = (flag_a || (armed && fin_a)) && (flag_b || (armed && fin_b));
    fs_launch = entry && ((state == S_LI_FS) || (state == S_CS_FS));
    ws_load   = entry && (state == S_LO_WS);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LI_FS;
      S_LI_FS: if (armed && fs_finish) state_nxt = S_LI_CT;
      S_LI_CT: if (armed && ct_finish) state_nxt = fs_last ? S_LO_CS : S_CS_FS;
      S_CS_FS: if (both_done) state_nxt = S_CT_WS;
      S_CT_WS: if (both_done) state_nxt = fs_last ? S_LO_CS : S_CS_FS;
      S_LO_CS: if (armed && cs_finish) state_nxt = S_LO_WS;
      S_LO_WS: if (armed && ws_finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    leave = (state_nxt != state);
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      entry    <= 1'b0;
      flag_a   <= 1'b0;
      flag_b   <= 1'b0;
      fs_start <= 1'b0;
      ct_start <= 1'b0;
      cs_start <= 1'b0;
      ws_start <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
      sram_sel <= 1'b0;
      fs_seg   <= 2'd0;
      fs_row   <= 5'd0;
      fs_col   <= 6'd0;
      ws_seg   <= 2'd0;
      ws_row   <= 5'd0;
      ws_col   <= 6'd0;
      nxt_seg  <= 2'd0;
      nxt_row  <= 5'd0;
      nxt_col  <= 6'd0;
    end else begin
      state    <= state_nxt;
      entry    <= leave;
      fs_start <= 1'b0;
      ct_start <= 1'b0;
      cs_start <= 1'b0;
      ws_start <= 1'b0;
      finish   <= leave && (state_nxt == S_DONE);

      // SRAM ownership only moves on a transition, when neither FS nor WS is
      // mid-transfer.
      if (leave) begin
        flag_a   <= 1'b0;
        flag_b   <= 1'b0;
        sram_sel <= (state_nxt == S_CT_WS) || (state_nxt == S_LO_WS);
      end else if (overlap && armed) begin
        flag_a <= flag_a || fin_a;
        flag_b <= flag_b || fin_b;
      end

      if ((state == S_IDLE) && start) begin
        busy    <= 1'b1;
        fs_seg  <= 2'd0;
        fs_row  <= 5'd0;
        fs_col  <= 6'd0;
        ws_seg  <= 2'd0;
        ws_row  <= 5'd0;
        ws_col  <= 6'd0;
        nxt_seg <= 2'd0;
        nxt_row <= 5'd0;
        nxt_col <= 6'd0;
      end
      if (state == S_DONE) busy <= 1'b0;

      if (entry) begin
        case (state)
          S_LI_FS: fs_start <= 1'b1;
          S_LI_CT: ct_start <= 1'b1;
          S_CS_FS: begin
            cs_start <= 1'b1;
            fs_start <= 1'b1;
          end
          S_CT_WS: begin
            ct_start <= 1'b1;
            ws_start <= 1'b1;
          end
          S_LO_CS: cs_start <= 1'b1;
          S_LO_WS: ws_start <= 1'b1;
          default: ;
        endcase
      end

      // The write index trails the fetch index by one block: it takes the old
      // fetch coordinates whenever FS moves on, and catches up for the final WS.
      if (fs_launch) begin
        fs_seg  <= nxt_seg;
        fs_row  <= nxt_row;
        fs_col  <= nxt_col;
        nxt_seg <= adv_seg;
        nxt_row <= adv_row;
        nxt_col <= adv_col;
        ws_seg  <= fs_seg;
        ws_row  <= fs_row;
        ws_col  <= fs_col;
      end else if (ws_load) begin
        ws_seg <= fs_seg;
        ws_row <= fs_row;
        ws_col <= fs_col;
      end
    end
  end

`ifdef M2_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      stall_cnt <= 32'd0;
    end else if ((state == S_IDLE) && start) begin
      stall_cnt <= 32'd0;
    end else if (overlap && (flag_a ^ flag_b)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall = stall_cnt;
`else
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_m2_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_m2_block_scheduler
//
// Bench for m2_block_scheduler with a 2x(2+1+1) block image (8 blocks).
// Sub-block responders pulse finish a programmable number of cycles after
// each launch. The stimulus process queues the expected raster walk for FS and
// WS; a monitor pops and compares on every launch, and checks launch timing
// against the rule "a launch comes two cycles after the last prerequisite
// finish" plus SRAM ownership.
// -----------------------------------------------------------------------------
module tb_m2_block_scheduler;

  localparam int BR   = 2;
  localparam int YC   = 2;
  localparam int UC   = 1;
  localparam int NBLK = BR * (YC + 2 * UC);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        finish;
  logic        fs_start, ct_start, cs_start, ws_start;
  logic [3:0]  fin_drv = 4'b0;
  logic        ws_spur = 1'b0;
  logic [1:0]  fs_seg, ws_seg;
  logic [4:0]  fs_row, ws_row;
  logic [5:0]  fs_col, ws_col;
  logic        sram_sel, busy;
  logic [31:0] perf_stall;

  m2_block_scheduler #(
    .BLK_ROWS   (BR),
    .Y_BLK_COLS (YC),
    .UV_BLK_COLS(UC)
  ) dut (
    .Clock_50  (clk),
    .Resetn    (rst_n),
    .start     (start),
    .finish    (finish),
    .fs_start  (fs_start),
    .ct_start  (ct_start),
    .cs_start  (cs_start),
    .ws_start  (ws_start),
    .fs_finish (fin_drv[0]),
    .ct_finish (fin_drv[1]),
    .cs_finish (fin_drv[2]),
    .ws_finish (fin_drv[3] | ws_spur),
    .fs_seg    (fs_seg),
    .fs_row    (fs_row),
    .fs_col    (fs_col),
    .ws_seg    (ws_seg),
    .ws_row    (ws_row),
    .ws_col    (ws_col),
    .sram_sel  (sram_sel),
    .busy      (busy),
    .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int err = 0;

  function automatic void chk(string name, longint act, longint exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  // Sub-block responders; index 0=FS 1=CT 2=CS 3=WS.
  int   dly[4];
  bit   rand_dly = 1'b0;
  int   cnt[4] = '{0, 0, 0, 0};
  int   fin_cyc[4] = '{-100, -100, -100, -100};
  wire [3:0] st = {ws_start, cs_start, ct_start, fs_start};

  always @(negedge clk) begin
    logic [3:0] f;
    f = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        cnt[i] = 0;
      end else begin
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) begin
            f[i] = 1'b1;
            fin_cyc[i] = cyc;
          end
        end
        if (st[i]) cnt[i] = rand_dly ? int'($urandom_range(1, 15)) : dly[i];
      end
    end
    fin_drv = f;
  end

  // Scoreboard shared between stimulus and monitor.
  logic [12:0] fs_q[$];
  logic [12:0] ws_q[$];
  int pass_id = 0;
  int start_cyc = 0;

  // Monitor state.
  int last_pass = 0;
  int n_l[4] = '{0, 0, 0, 0};
  int n_fin = 0;
  bit fs_act = 1'b0;
  bit ws_act = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      fs_act = 1'b0;
      ws_act = 1'b0;
    end else begin
      logic [12:0] e;
      if (pass_id != last_pass) begin
        last_pass = pass_id;
        n_l = '{0, 0, 0, 0};
        n_fin = 0;
      end
      // A finish seen here was sampled by the DUT at this edge: transfer over.
      if (fin_drv[0]) fs_act = 1'b0;
      if (fin_drv[3]) ws_act = 1'b0;
      if (fs_start) fs_act = 1'b1;
      if (ws_start) ws_act = 1'b1;
      if (fs_act) chk("sram_sel_fs", sram_sel, 0);
      if (ws_act) chk("sram_sel_ws", sram_sel, 1);
      if (fs_act || ws_act) chk("fs_ws_exclusive", int'(fs_act & ws_act), 0);

      if (fs_start) begin
        chk("fs_launch_cyc", cyc,
            (n_l[0] == 0) ? start_cyc + 2 : imax(fin_cyc[1], fin_cyc[3]) + 2);
        e = (fs_q.size() > 0) ? fs_q.pop_front() : 13'h1fff;
        chk("fs_coord", {fs_seg, fs_row, fs_col}, e);
        chk("busy_during_pass", busy, 1);
        n_l[0]++;
      end
      if (ct_start) begin
        chk("ct_launch_cyc", cyc,
            (n_l[1] == 0) ? fin_cyc[0] + 2 : imax(fin_cyc[2], fin_cyc[0]) + 2);
        n_l[1]++;
      end
      if (cs_start) begin
        chk("cs_launch_cyc", cyc, imax(fin_cyc[1], fin_cyc[3]) + 2);
        n_l[2]++;
      end
      if (ws_start) begin
        chk("ws_launch_cyc", cyc, imax(fin_cyc[2], fin_cyc[0]) + 2);
        e = (ws_q.size() > 0) ? ws_q.pop_front() : 13'h1fff;
        chk("ws_coord", {ws_seg, ws_row, ws_col}, e);
        n_l[3]++;
      end
      if (finish) begin
        chk("finish_cyc", cyc, fin_cyc[3] + 1);
        n_fin++;
      end
    end
  end

  task automatic set_dly(int f, int t, int c, int w);
    dly[0] = f;
    dly[1] = t;
    dly[2] = c;
    dly[3] = w;
  endtask

  task automatic begin_pass();
    logic [12:0] e;
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < BR; r++)
        for (int c = 0; c < ((s == 0) ? YC : UC); c++) begin
          e = {2'(s), 5'(r), 6'(c)};
          fs_q.push_back(e);
          ws_q.push_back(e);
        end
    @(negedge clk);
    pass_id++;
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_pass(string tag);
    for (int i = 0; i < 4000; i++) begin
      if (n_fin > 0) break;
      @(negedge clk);
    end
    chk({tag, "_finish_seen"}, n_fin, 1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_finish_count"}, n_fin, 1);
    chk({tag, "_fs_launches"}, n_l[0], NBLK);
    chk({tag, "_ct_launches"}, n_l[1], NBLK);
    chk({tag, "_cs_launches"}, n_l[2], NBLK);
    chk({tag, "_ws_launches"}, n_l[3], NBLK);
    chk({tag, "_fs_q_left"}, fs_q.size(), 0);
    chk({tag, "_ws_q_left"}, ws_q.size(), 0);
  endtask

  task automatic wait_count(int idx, int target, string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (n_l[idx] >= target) break;
      @(negedge clk);
    end
    chk({tag, "_reached"}, int'(n_l[idx] >= target), 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_fs_start"}, fs_start, 0);
    chk({tag, "_ct_start"}, ct_start, 0);
    chk({tag, "_cs_start"}, cs_start, 0);
    chk({tag, "_ws_start"}, ws_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sram_sel"}, sram_sel, 0);
    chk({tag, "_fs_coord"}, {fs_seg, fs_row, fs_col}, 0);
    chk({tag, "_ws_coord"}, {ws_seg, ws_row, ws_col}, 0);
    chk({tag, "_perf"}, perf_stall, 0);
  endtask

  function automatic int perf_expect();
`ifdef M2_PERF_CNT_EN
    return (NBLK - 1) * (iabs(dly[0] - dly[2]) + iabs(dly[1] - dly[3]));
`else
    return 0;
`endif
  endfunction

  initial begin
    set_dly(5, 5, 5, 5);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Baseline pass, every sub-block 5 cycles.
    begin_pass();
    end_pass("base");
    chk("base_perf", perf_stall, perf_expect());

    // Overlap ordering: CS early / FS late, then swapped.
    set_dly(20, 4, 3, 9);
    begin_pass();
    end_pass("cs_first");
    set_dly(3, 9, 20, 4);
    begin_pass();
    end_pass("fs_first");

    // Stall counting with unequal CS/FS and equal CT/WS.
    set_dly(12, 6, 5, 6);
    begin_pass();
    end_pass("perf");
    chk("perf_total", perf_stall, perf_expect());

    // Simultaneous finishes; stall count restarts from zero.
    set_dly(7, 4, 7, 4);
    begin_pass();
    end_pass("same_cycle");
    chk("same_cycle_perf", perf_stall, perf_expect());

    // Spurious ws_finish while in S_CS_FS, and start pulsed mid-pass.
    set_dly(9, 4, 6, 8);
    begin_pass();
    wait_count(2, 2, "spur_wait");
    @(negedge clk);
    ws_spur = 1'b1;
    @(negedge clk);
    ws_spur = 1'b0;
    wait_count(3, 4, "midstart_wait");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_pass("robust");

    // Random sub-block latencies.
    rand_dly = 1'b1;
    begin_pass();
    end_pass("random");

    // Reset while in S_CT_WS, then a clean pass.
    rand_dly = 1'b0;
    set_dly(6, 6, 6, 6);
    begin_pass();
    wait_count(3, 3, "rst_wait");
    @(negedge clk);
    chk("pre_reset_sram_sel", sram_sel, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    chk_all_zero("midreset_hold");
    fs_q.delete();
    ws_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rand_dly = 1'b1;
    begin_pass();
    end_pass("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
